// File: rtl/vector_mem_access_unit.sv
// Vector memory access unit: splits scalar and masked/strided vector loads and stores into
// per-element d_cache accesses. Define VMAU_STRIDED_EN to honour the stride port.
`ifndef MEM_CTR_NOP
`define MEM_CTR_NOP   2'd0
`define MEM_CTR_LOAD  2'd1
`define MEM_CTR_STORE 2'd2
`endif
`ifndef ONE_BYTE
`define ONE_BYTE  3'd0
`define TWO_BYTE  3'd1
`define FOUR_BYTE 3'd2
`endif
`ifndef MEM_RESTING
`define MEM_RESTING  2'd0
`define MEM_WORKING  2'd1
`define MEM_STALL    2'd2
`define MEM_FINISHED 2'd3
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING  2'd0
`define D_CACHE_WORKING  2'd1
`define D_CACHE_FINISHED 2'd2
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP   2'd0
`define D_CACHE_LOAD  2'd1
`define D_CACHE_STORE 2'd2
`endif

module vector_mem_access_unit #(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned LEN              = 32,
    parameter int unsigned VECTOR_SIZE      = 8,
    parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_access_enabled,
    input  logic                       is_vector,
    input  logic [1:0]                 data_vis_signal,
    input  logic [2:0]                 mem_data_type,
    input  logic [ADDR_WIDTH-1:0]      data_addr,
    input  logic [ADDR_WIDTH-1:0]      stride,
    input  logic [ENTRY_INDEX_SIZE:0]  length,
    input  logic                       vm,
    input  logic [VECTOR_SIZE-1:0]     mask,
    input  logic [LEN-1:0]             written_scalar_data,
    input  logic [LEN*VECTOR_SIZE-1:0] written_vector_data,
    output logic [LEN-1:0]             scalar_data,
    output logic [LEN*VECTOR_SIZE-1:0] vector_data,
    output logic [1:0]                 mem_vis_status,
    input  logic [1:0]                 d_cache_status,
    input  logic [LEN-1:0]             mem_data,
    output logic [1:0]                 cache_vis_signal,
    output logic [ADDR_WIDTH-1:0]      mem_vis_addr,
    output logic [2:0]                 d_cache_data_type,
    output logic [LEN-1:0]             cache_written_data
);

    localparam int unsigned IdxW = ENTRY_INDEX_SIZE + 1;

    typedef enum logic [2:0] {StIdle, StScan, StIssue, StWait, StDone} state_e;

    state_e                     state_q, state_d;
    logic                       is_vec_q, is_vec_d;
    logic                       is_store_q, is_store_d;
    logic                       vm_q, vm_d;
    logic [2:0]                 ew_q, ew_d;
    logic [ADDR_WIDTH-1:0]      base_q, base_d;
    logic [IdxW-1:0]            len_q, len_d;
    logic [IdxW-1:0]            cur_q, cur_d;
    logic [ENTRY_INDEX_SIZE-1:0] elem_q, elem_d;
    logic [VECTOR_SIZE-1:0]     mask_q, mask_d;
    logic [LEN*VECTOR_SIZE-1:0] wvec_q, wvec_d;
    logic [LEN-1:0]             wscalar_q, wscalar_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LEN-1:0]             wdata_q, wdata_d;
    logic [LEN-1:0]             sdata_q, sdata_d;
    logic [LEN*VECTOR_SIZE-1:0] vdata_q, vdata_d;

    logic                        scan_found;
    logic [ENTRY_INDEX_SIZE-1:0] scan_idx;
    logic [ADDR_WIDTH-1:0]       step;
    logic [ADDR_WIDTH-1:0]       elem_addr;
    logic [LEN-1:0]              elem_wdata;
    logic [2:0]                  ew_norm;
    logic [IdxW-1:0]             len_clamped;
    logic [IdxW-1:0]             cur_next;

`ifdef VMAU_STRIDED_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
`else
    logic unused_stride;
    assign unused_stride = ^stride;
`endif

    // Unknown element widths are handled as four-byte accesses.
    always_comb begin
        case (mem_data_type)
            `ONE_BYTE: ew_norm = `ONE_BYTE;
            `TWO_BYTE: ew_norm = `TWO_BYTE;
            default:   ew_norm = `FOUR_BYTE;
        endcase
    end

    assign len_clamped = (length > IdxW'(VECTOR_SIZE)) ? IdxW'(VECTOR_SIZE) : length;
    assign cur_next    = {1'b0, elem_q} + IdxW'(1);

    // Lowest active index at or above cur_q; skipped elements cost no cycles.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
            if ((vm_q || mask_q[i]) && (IdxW'(i) >= cur_q) && (IdxW'(i) < len_q)) begin
                scan_found = 1'b1;
                scan_idx   = ENTRY_INDEX_SIZE'(i);
            end
        end
    end

    always_comb begin
`ifdef VMAU_STRIDED_EN
        step = stride_q;
`else
        case (ew_q)
            `ONE_BYTE: step = ADDR_WIDTH'(1);
            `TWO_BYTE: step = ADDR_WIDTH'(2);
            default:   step = ADDR_WIDTH'(4);
        endcase
`endif
        elem_addr = base_q + ({{(ADDR_WIDTH - ENTRY_INDEX_SIZE){1'b0}}, scan_idx} * step);
    end

    always_comb begin
        elem_wdata = '0;
        if (is_vec_q) begin
            case (ew_q)
                `ONE_BYTE: elem_wdata[7:0]  = wvec_q[{scan_idx, 3'b000} +: 8];
                `TWO_BYTE: elem_wdata[15:0] = wvec_q[{scan_idx, 4'b0000} +: 16];
                default:   elem_wdata[31:0] = wvec_q[{scan_idx, 5'b00000} +: 32];
            endcase
        end else begin
            case (ew_q)
                `ONE_BYTE: elem_wdata[7:0]  = wscalar_q[7:0];
                `TWO_BYTE: elem_wdata[15:0] = wscalar_q[15:0];
                default:   elem_wdata[31:0] = wscalar_q[31:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        is_vec_d   = is_vec_q;
        is_store_d = is_store_q;
        vm_d       = vm_q;
        ew_d       = ew_q;
        base_d     = base_q;
        len_d      = len_q;
        cur_d      = cur_q;
        elem_d     = elem_q;
        mask_d     = mask_q;
        wvec_d     = wvec_q;
        wscalar_d  = wscalar_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sdata_d    = sdata_q;
        vdata_d    = vdata_q;
`ifdef VMAU_STRIDED_EN
        stride_d   = stride_q;
`endif
        cache_vis_signal = `D_CACHE_NOP;
        mem_vis_status   = `MEM_RESTING;

        case (state_q)
            StIdle: begin
                if (mem_access_enabled) begin
                    if (data_vis_signal == `MEM_CTR_LOAD || data_vis_signal == `MEM_CTR_STORE) begin
                        is_vec_d   = is_vector;
                        is_store_d = (data_vis_signal == `MEM_CTR_STORE);
                        vm_d       = vm | ~is_vector;
                        ew_d       = ew_norm;
                        base_d     = data_addr;
                        len_d      = is_vector ? len_clamped : IdxW'(1);
                        cur_d      = '0;
                        mask_d     = mask;
                        wvec_d     = written_vector_data;
                        wscalar_d  = written_scalar_data;
`ifdef VMAU_STRIDED_EN
                        stride_d   = stride;
`endif
                        // Masked-off and out-of-range elements of a vector load read as 0.
                        if (is_vector && data_vis_signal == `MEM_CTR_LOAD) vdata_d = '0;
                        state_d = StScan;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StScan: begin
                mem_vis_status = `MEM_WORKING;
                if (scan_found) begin
                    elem_d  = scan_idx;
                    addr_d  = elem_addr;
                    wdata_d = elem_wdata;
                    state_d = StIssue;
                end else begin
                    state_d = StDone;
                end
            end
            StIssue: begin
                if (d_cache_status == `D_CACHE_RESTING) begin
                    mem_vis_status   = `MEM_WORKING;
                    cache_vis_signal = is_store_q ? `D_CACHE_STORE : `D_CACHE_LOAD;
                    state_d          = StWait;
                end else begin
                    mem_vis_status = `MEM_STALL;
                end
            end
            StWait: begin
                mem_vis_status = `MEM_WORKING;
                if (d_cache_status == `D_CACHE_FINISHED) begin
                    if (!is_store_q) begin
                        if (is_vec_q) begin
                            case (ew_q)
                                `ONE_BYTE: vdata_d[{elem_q, 3'b000} +: 8]    = mem_data[7:0];
                                `TWO_BYTE: vdata_d[{elem_q, 4'b0000} +: 16]  = mem_data[15:0];
                                default:   vdata_d[{elem_q, 5'b00000} +: 32] = mem_data[31:0];
                            endcase
                        end else begin
                            sdata_d = mem_data;
                        end
                    end
                    cur_d   = cur_next;
                    state_d = (cur_next == len_q) ? StDone : StScan;
                end
            end
            StDone: begin
                mem_vis_status = `MEM_FINISHED;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            is_vec_q   <= 1'b0;
            is_store_q <= 1'b0;
            vm_q       <= 1'b0;
            ew_q       <= '0;
            base_q     <= '0;
            len_q      <= '0;
            cur_q      <= '0;
            elem_q     <= '0;
            mask_q     <= '0;
            wvec_q     <= '0;
            wscalar_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sdata_q    <= '0;
            vdata_q    <= '0;
`ifdef VMAU_STRIDED_EN
            stride_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_vec_q   <= is_vec_d;
            is_store_q <= is_store_d;
            vm_q       <= vm_d;
            ew_q       <= ew_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cur_q      <= cur_d;
            elem_q     <= elem_d;
            mask_q     <= mask_d;
            wvec_q     <= wvec_d;
            wscalar_q  <= wscalar_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sdata_q    <= sdata_d;
            vdata_q    <= vdata_d;
`ifdef VMAU_STRIDED_EN
            stride_q   <= stride_d;
`endif
        end
    end

    assign scalar_data        = sdata_q;
    assign vector_data        = vdata_q;
    assign mem_vis_addr       = addr_q;
    assign d_cache_data_type  = ew_q;
    assign cache_written_data = wdata_q;

endmodule
